// File: rtl/if_fetch_stage.sv
// IF stage: owns the fetch PC, drives the instruction-memory req/ack handshake and
// fills the IF/ID register, with a one-entry hold buffer for ID stalls and flush on redirect.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] npc_in,
  input  logic        stall,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_instr_q, buf_instr_d;

  // NOTE: every signal is given its hold value first so no path through the
  // case statement leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    id_pc_d     = id_pc_q;
    id_instr_d  = id_instr_q;
    id_valid_d  = id_valid_q;
    buf_pc_d    = buf_pc_q;
    buf_instr_d = buf_instr_q;

    unique case (state_q)
      BOOT: state_d = FETCH;

      FETCH: begin
        if (flush) begin
          pc_d       = npc_in;
          id_valid_d = 1'b0;
          id_instr_d = NOP_INSTR;
        end else if (imem_ack && !stall) begin
          id_pc_d    = pc_q;
          id_instr_d = imem_rdata;
          id_valid_d = 1'b1;
          pc_d       = npc_in;
        end else if (imem_ack) begin
          // ID is busy: park the returned word so the fetch is not repeated.
          buf_pc_d    = pc_q;
          buf_instr_d = imem_rdata;
          state_d     = HOLD;
        end else if (!stall) begin
          id_valid_d = 1'b0;
          id_instr_d = NOP_INSTR;
        end
      end

      HOLD: begin
        if (flush) begin
          pc_d       = npc_in;
          id_valid_d = 1'b0;
          id_instr_d = NOP_INSTR;
          state_d    = FETCH;
        end else if (!stall) begin
          id_pc_d    = buf_pc_q;
          id_instr_d = buf_instr_q;
          id_valid_d = 1'b1;
          pc_d       = npc_in;
          state_d    = FETCH;
        end
      end

      default: state_d = BOOT;
    endcase
  end

  // NOTE: the hold buffer is ordinary datapath but is still reset, so a stale
  // word can never leak out and simulation never propagates X from it.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (rst) begin
      state_q     <= BOOT;
      pc_q        <= RESET_PC;
      id_pc_q     <= 32'h0;
      id_instr_q  <= NOP_INSTR;
      id_valid_q  <= 1'b0;
      buf_pc_q    <= 32'h0;
      buf_instr_q <= NOP_INSTR;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      id_pc_q     <= id_pc_d;
      id_instr_q  <= id_instr_d;
      id_valid_q  <= id_valid_d;
      buf_pc_q    <= buf_pc_d;
      buf_instr_q <= buf_instr_d;
    end
  end

  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign pc_out      = pc_q;
  assign if_id_pc    = id_pc_q;
  assign if_id_instr = id_instr_q;
  assign if_id_valid = id_valid_q;

endmodule
